hls_slave_port_driver: RTL and testbench

- Synthesizable host-side initiator for the slave memory port and start/done handshake of a Bambu-generated accelerator (`main`).
- Sequence: load an input byte stream into the accelerator's slave RAM window, pulse `start_port`, count cycles until `done_port`, read a result window back, emit it as a byte stream.
- Sits between an on-board host interface (UART/DMA bridge) and the accelerator. Replaces the simulation-only file loader on FPGA builds.

---
 rtl/hls_drv_pkg.sv | 24 ++
 rtl/hls_slave_port_driver_if.sv | 31 +++
 rtl/hls_slave_port_driver_req.sv | 64 ++++++
 rtl/hls_slave_port_driver.sv | 208 ++++++++++++++++++++
 tb/tb_hls_slave_port_driver.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/hls_drv_pkg.sv
// Shared definitions for the Bambu slave-port host driver.
//   drv_state_e : top-level command sequencer states
//   BYTE_W      : width of one streamed byte
//   BYTE_SIZE   : data_ram_size value for a single-byte access (in bits)
//   NUM_CH      : channels carried on the accelerator slave port
package hls_drv_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOAD_WAIT,
    ST_START,
    ST_RUN,
    ST_READ,
    ST_READ_WAIT,
    ST_EMIT,
    ST_FINISH
  } drv_state_e;

  localparam int BYTE_W    = 8;
  localparam int BYTE_SIZE = 8;
  localparam int NUM_CH    = 2;

endpackage

// File: rtl/hls_slave_port_driver_if.sv
// Accelerator slave RAM port, both channels packed as Bambu emits them
// (channel 0 in the low slice of every vector).
//   master : the driver (issues oe/we/addr/wdata/size, sees rdata/DataRdy)
//   slave  : the accelerator side
interface hls_slave_port_driver_if
  import hls_drv_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64,
  parameter int SIZE_W = 7
);

  logic [NUM_CH-1:0]        S_oe_ram;
  logic [NUM_CH-1:0]        S_we_ram;
  logic [NUM_CH*ADDR_W-1:0] S_addr_ram;
  logic [NUM_CH*DATA_W-1:0] S_Wdata_ram;
  logic [NUM_CH*SIZE_W-1:0] S_data_ram_size;
  logic [NUM_CH*DATA_W-1:0] Sout_Rdata_ram;
  logic [NUM_CH-1:0]        Sout_DataRdy;

  modport master (
    output S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    input  Sout_Rdata_ram, Sout_DataRdy
  );

  modport slave (
    input  S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size,
    output Sout_Rdata_ram, Sout_DataRdy
  );

endinterface

// File: rtl/hls_slave_port_driver_req.sv
// Single-channel request/hold/complete engine for the slave RAM port.
// A one-cycle req is captured into registered bus outputs which stay
// stable until ram_rdy; ack is the completion cycle (ram_rdy while a
// request is outstanding), rdata is valid in that same cycle.
//   req/we/addr/wdata : request from the sequencer (ignored while pending)
//   rdata/ack         : completion back to the sequencer
//   ram_*             : channel-0 slice of the slave port
module hls_slave_req
  import hls_drv_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int SIZE_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata,
  output logic              ack,
  output logic              ram_oe,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [BYTE_W-1:0] ram_wdata,
  output logic [SIZE_W-1:0] ram_size,
  input  logic [BYTE_W-1:0] ram_rdata,
  input  logic              ram_rdy
);

  logic pending;

  // DataRdy outside an outstanding request is not ours and is dropped here.
  assign ack   = pending & ram_rdy;
  assign rdata = ram_rdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending   <= 1'b0;
      ram_oe    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_size  <= '0;
    end else if (pending) begin
      if (ram_rdy) begin
        pending   <= 1'b0;
        ram_oe    <= 1'b0;
        ram_we    <= 1'b0;
        ram_addr  <= '0;
        ram_wdata <= '0;
        ram_size  <= '0;
      end
    end else if (req) begin
      pending   <= 1'b1;
      ram_oe    <= ~we;
      ram_we    <= we;
      ram_addr  <= addr;
      ram_wdata <= we ? wdata : '0;
      ram_size  <= SIZE_W'(BYTE_SIZE);
    end
  end

endmodule

// File: rtl/hls_slave_port_driver.sv
// Host-side initiator for a Bambu accelerator: streams bytes into the
// slave RAM window, pulses start_port, times the run until done_port,
// then reads a result window back out as a byte stream.
//   clock/reset        : system clock, async active-high reset
//   cfg_*              : command (go strobe, load/read windows)
//   in_*               : input byte stream (valid/ready)
//   out_*              : result byte stream (valid/ready)
//   bus                : accelerator slave RAM port (channel 0 only)
//   start_port/done_port : accelerator handshake
//   busy/run_cycles/timed_out/cmd_done : status
module hls_slave_port_driver
  import hls_drv_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 64,
  parameter int SIZE_W  = 7,
  parameter int TIMEOUT = 200000000,
  parameter int CNT_W   = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_go,
  input  logic [ADDR_W-1:0]        cfg_load_base,
  input  logic [ADDR_W:0]          cfg_load_len,
  input  logic [ADDR_W-1:0]        cfg_read_base,
  input  logic [ADDR_W:0]          cfg_read_len,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [BYTE_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  hls_slave_port_driver_if.master  bus,
  output logic                     start_port,
  input  logic                     done_port,
  output logic                     busy,
  output logic [CNT_W-1:0]         run_cycles,
  output logic                     timed_out,
  output logic                     cmd_done
);

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  drv_state_e        state;
  logic [ADDR_W-1:0] load_base, read_base;
  logic [ADDR_W:0]   load_len, read_len, idx, idx_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;

  logic              req, req_we, req_ack;
  logic [ADDR_W-1:0] req_addr;
  logic [BYTE_W-1:0] req_wdata, req_rdata;

  logic              ram_oe, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [BYTE_W-1:0] ram_wdata;
  logic [SIZE_W-1:0] ram_size;

  assign busy     = (state != ST_IDLE);
  assign in_ready = (state == ST_LOAD);
  assign idx_nxt  = idx + 1'b1;
  assign cnt_nxt  = (cnt == '1) ? cnt : cnt + CNT_W'(1);

  // Request issue: the byte is handed over in the accept cycle; address
  // arithmetic wraps inside the ADDR_W window.
  always_comb begin
    req       = 1'b0;
    req_we    = 1'b0;
    req_addr  = load_base + idx[ADDR_W-1:0];
    req_wdata = in_data;
    case (state)
      ST_LOAD: begin
        req    = in_valid;
        req_we = 1'b1;
      end
      ST_READ: begin
        req      = 1'b1;
        req_addr = read_base + idx[ADDR_W-1:0];
      end
      default: ;
    endcase
  end

  hls_slave_req #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W)) u_req (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (req_we),
    .addr      (req_addr),
    .wdata     (req_wdata),
    .rdata     (req_rdata),
    .ack       (req_ack),
    .ram_oe    (ram_oe),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_size  (ram_size),
    .ram_rdata (bus.Sout_Rdata_ram[BYTE_W-1:0]),
    .ram_rdy   (bus.Sout_DataRdy[0])
  );

  // Channel 1 is never used; all of its fields are tied low.
  assign bus.S_oe_ram        = {{(NUM_CH-1){1'b0}}, ram_oe};
  assign bus.S_we_ram        = {{(NUM_CH-1){1'b0}}, ram_we};
  assign bus.S_addr_ram      = {{((NUM_CH-1)*ADDR_W){1'b0}}, ram_addr};
  assign bus.S_Wdata_ram     = {{(NUM_CH*DATA_W-BYTE_W){1'b0}}, ram_wdata};
  assign bus.S_data_ram_size = {{((NUM_CH-1)*SIZE_W){1'b0}}, ram_size};

  logic unused_rd;
  assign unused_rd = ^{bus.Sout_Rdata_ram[NUM_CH*DATA_W-1:BYTE_W],
                       bus.Sout_DataRdy[NUM_CH-1:1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      load_base  <= '0;
      load_len   <= '0;
      read_base  <= '0;
      read_len   <= '0;
      idx        <= '0;
      cnt        <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      start_port <= 1'b0;
      run_cycles <= '0;
      timed_out  <= 1'b0;
      cmd_done   <= 1'b0;
    end else begin
      start_port <= 1'b0;
      cmd_done   <= 1'b0;
      case (state)
        ST_IDLE: if (cfg_go) begin
          load_base <= cfg_load_base;
          load_len  <= cfg_load_len;
          read_base <= cfg_read_base;
          read_len  <= cfg_read_len;
          timed_out <= 1'b0;
          idx       <= '0;
          if (cfg_load_len != '0) state <= ST_LOAD;
          else begin
            state      <= ST_START;
            start_port <= 1'b1;
          end
        end
        ST_LOAD: if (in_valid) state <= ST_LOAD_WAIT;
        ST_LOAD_WAIT: if (req_ack) begin
          idx <= idx_nxt;
          if (idx_nxt == load_len) begin
            state      <= ST_START;
            start_port <= 1'b1;
          end else begin
            state <= ST_LOAD;
          end
        end
        // The START cycle itself is cycle 1 of the run.
        ST_START: begin
          cnt <= CNT_W'(1);
          idx <= '0;
          if (done_port) begin
            run_cycles <= CNT_W'(1);
            if (read_len != '0) state <= ST_READ;
            else begin
              state    <= ST_FINISH;
              cmd_done <= 1'b1;
            end
          end else begin
            state <= ST_RUN;
          end
        end
        // cnt holds the cycles already elapsed; this cycle makes cnt_nxt.
        ST_RUN: begin
          cnt <= cnt_nxt;
          if (done_port) begin
            run_cycles <= cnt_nxt;
            if (read_len != '0) state <= ST_READ;
            else begin
              state    <= ST_FINISH;
              cmd_done <= 1'b1;
            end
          end else if (cnt_nxt >= TO_LIM) begin
            run_cycles <= cnt_nxt;
            timed_out  <= 1'b1;
            state      <= ST_FINISH;
            cmd_done   <= 1'b1;
          end
        end
        ST_READ: state <= ST_READ_WAIT;
        ST_READ_WAIT: if (req_ack) begin
          out_data  <= req_rdata;
          out_valid <= 1'b1;
          state     <= ST_EMIT;
        end
        ST_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          idx       <= idx_nxt;
          if (idx_nxt == read_len) begin
            state    <= ST_FINISH;
            cmd_done <= 1'b1;
          end else begin
            state <= ST_READ;
          end
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hls_slave_port_driver.sv
// Directed bench for hls_slave_port_driver: a table of commands, each run
// against a slave-RAM stub (programmable DataRdy latency, read data =
// addr[7:0]) and a done_port stub, plus hand sequences for reset mid-load.
module tb_hls_slave_port_driver;

  logic        clock, reset;
  logic        cfg_go;
  logic [8:0]  cfg_load_base, cfg_read_base;
  logic [9:0]  cfg_load_len, cfg_read_len;
  logic [7:0]  in_data, out_data;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        start_port, done_port, busy, timed_out, cmd_done;
  logic [31:0] run_cycles;

  hls_slave_port_driver_if #(.ADDR_W(9), .DATA_W(64), .SIZE_W(7)) bus ();

  hls_slave_port_driver #(
    .ADDR_W(9), .DATA_W(64), .SIZE_W(7), .TIMEOUT(50), .CNT_W(32)
  ) dut (
    .clock(clock), .reset(reset), .cfg_go(cfg_go),
    .cfg_load_base(cfg_load_base), .cfg_load_len(cfg_load_len),
    .cfg_read_base(cfg_read_base), .cfg_read_len(cfg_read_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bus(bus), .start_port(start_port), .done_port(done_port),
    .busy(busy), .run_cycles(run_cycles), .timed_out(timed_out),
    .cmd_done(cmd_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave RAM stub: completes after `lat` cycles of a held request. With
  // no request outstanding DataRdy[0] is driven high (must be ignored);
  // channel-1 DataRdy is always high.
  int   lat = 0;
  int   wait_cnt = 0;
  logic req_act, rdy0;
  assign req_act = bus.S_oe_ram[0] | bus.S_we_ram[0];
  assign rdy0    = req_act ? (wait_cnt >= lat) : 1'b1;
  assign bus.Sout_DataRdy   = {1'b1, rdy0};
  assign bus.Sout_Rdata_ram = {{15{8'hA5}}, bus.S_addr_ram[7:0]};
  always @(posedge clock)
    if (req_act && !rdy0) wait_cnt <= wait_cnt + 1;
    else                  wait_cnt <= 0;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0]  lb;
    logic [9:0]  ll;
    logic [8:0]  rb;
    logic [9:0]  rl;
    int          lat;
    int          dd;        // done delay after start: 0 = high at start, <0 = never
    bit          tog;       // out_ready toggles every other cycle
    bit          go_again;  // extra cfg_go while busy
    logic [31:0] exp_rc;
    bit          exp_to;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int   starts = 0, dones = 0, viol = 0, start_cyc = -1, first_oe = -1;
    int   in_idx = 0, exp_reads;
    bit   prev_acc = 0, fin = 0;
    logic [8:0] waddr[$], raddr[$];
    logic [7:0] wdat[$], rbytes[$];
    logic [6:0] rsize[$];
    lat = v.lat;
    done_port = (v.dd == 0);
    @(negedge clock);
    cfg_load_base = v.lb; cfg_load_len = v.ll;
    cfg_read_base = v.rb; cfg_read_len = v.rl;
    cfg_go = 1'b1;
    @(negedge clock);
    cfg_go = 1'b0;
    // scramble cfg after the strobe: the DUT must use its latched copy
    cfg_load_base = 9'h155; cfg_load_len = 10'h2AA;
    cfg_read_base = 9'h0AA; cfg_read_len = 10'h155;
    for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
      if (start_port) begin starts++; start_cyc = cyc; end
      if (cmd_done) begin dones++; fin = 1; end
      if (bus.S_oe_ram[0]) begin
        if (first_oe < 0) first_oe = cyc;
        if (out_valid) viol++;
      end
      if (rdy0 && bus.S_we_ram[0]) begin
        waddr.push_back(bus.S_addr_ram[8:0]);
        wdat.push_back(bus.S_Wdata_ram[7:0]);
        rsize.push_back(bus.S_data_ram_size[6:0]);
      end
      if (rdy0 && bus.S_oe_ram[0]) begin
        raddr.push_back(bus.S_addr_ram[8:0]);
        rsize.push_back(bus.S_data_ram_size[6:0]);
      end
      if (prev_acc) in_idx++;
      in_valid = (in_idx < int'(v.ll));
      in_data  = 8'((in_idx + 1) * 17);
      prev_acc = in_valid && in_ready;
      out_ready = v.tog ? (cyc % 2 == 1) : 1'b1;
      if (out_valid && out_ready) rbytes.push_back(out_data);
      if (v.dd > 0 && start_cyc >= 0 && cyc - start_cyc == v.dd) done_port = 1'b1;
      else if (v.dd != 0 || (start_cyc >= 0 && cyc > start_cyc)) done_port = 1'b0;
      if (v.go_again) begin
        if (cyc == 2) begin cfg_go = 1'b1; cfg_load_len = 10'd5; end
        else cfg_go = 1'b0;
      end
      @(negedge clock);
    end
    in_valid = 1'b0; cfg_go = 1'b0; done_port = 1'b0;
    repeat (4) begin
      if (start_port) starts++;
      if (cmd_done) dones++;
      @(negedge clock);
    end
    exp_reads = v.exp_to ? 0 : int'(v.rl);
    chk("cmd_done_seen", 64'(fin), 64'd1);
    chk("start_pulses", 64'(starts), 64'd1);
    chk("cmd_done_pulses", 64'(dones), 64'd1);
    chk("run_cycles", 64'(run_cycles), 64'(v.exp_rc));
    chk("timed_out", 64'(timed_out), 64'(v.exp_to));
    chk("busy_after", 64'(busy), 64'd0);
    chk("write_count", 64'(waddr.size()), 64'(v.ll));
    for (int i = 0; i < waddr.size() && i < int'(v.ll); i++) begin
      chk("write_addr", 64'(waddr[i]), 64'((int'(v.lb) + i) & 32'h1FF));
      chk("write_data", 64'(wdat[i]), 64'(8'((i + 1) * 17)));
    end
    chk("read_req_count", 64'(raddr.size()), 64'(exp_reads));
    chk("read_byte_count", 64'(rbytes.size()), 64'(exp_reads));
    for (int i = 0; i < raddr.size() && i < exp_reads; i++)
      chk("read_addr", 64'(raddr[i]), 64'((int'(v.rb) + i) & 32'h1FF));
    for (int i = 0; i < rbytes.size() && i < exp_reads; i++)
      chk("read_byte", 64'(rbytes[i]), 64'((int'(v.rb) + i) & 32'hFF));
    for (int i = 0; i < rsize.size(); i++)
      chk("req_size", 64'(rsize[i]), 64'd8);
    chk("oe_while_out_valid", 64'(viol), 64'd0);
    if (v.dd == 0 && exp_reads > 0)
      chk("readback_oe_latency", 64'(first_oe - start_cyc), 64'd2);
  endtask

  vec_t vecs[5];
  vec_t rv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            lb      ll     rb      rl    lat dd  tog go2 rc     to
    vecs[0] = '{9'h010, 10'd4, 9'h000, 10'd0, 2, 10, 0, 0, 32'd11, 0};
    vecs[1] = '{9'h000, 10'd0, 9'h1FF, 10'd3, 1, 5,  1, 0, 32'd6,  0};
    vecs[2] = '{9'h1FE, 10'd3, 9'h020, 10'd2, 0, 0,  0, 0, 32'd1,  0};
    vecs[3] = '{9'h100, 10'd1, 9'h005, 10'd2, 1, -1, 0, 0, 32'd50, 1};
    vecs[4] = '{9'h000, 10'd0, 9'h000, 10'd0, 0, 3,  0, 1, 32'd4,  0};

    reset = 1'b1; cfg_go = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1; done_port = 1'b0;
    cfg_load_base = '0; cfg_load_len = '0; cfg_read_base = '0; cfg_read_len = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start_port", 64'(start_port), 64'd0);
    chk("rst_outs", 64'({out_valid, cmd_done, timed_out, in_ready}), 64'd0);
    chk("rst_run_cycles", 64'(run_cycles), 64'd0);
    chk("rst_bus_req", 64'({bus.S_oe_ram, bus.S_we_ram}), 64'd0);
    chk("rst_bus_size", 64'(bus.S_data_ram_size), 64'd0);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // reset while a write request is held on the bus
    lat = 5;
    in_valid = 1'b1; in_data = 8'hAA;
    cfg_load_base = 9'h080; cfg_load_len = 10'd4;
    cfg_read_base = 9'h000; cfg_read_len = 10'd0;
    cfg_go = 1'b1;
    @(negedge clock);
    cfg_go = 1'b0;
    for (int i = 0; i < 20 && !bus.S_we_ram[0]; i++) @(negedge clock);
    chk("midload_we_before", 64'(bus.S_we_ram[0]), 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("midload_we_async", 64'(bus.S_we_ram), 64'd0);
    chk("midload_start_busy", 64'({start_port, busy, in_ready}), 64'd0);
    chk("midload_run_cycles", 64'(run_cycles), 64'd0);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    rv = '{9'h080, 10'd2, 9'h07F, 10'd1, 1, 2, 0, 0, 32'd3, 0};
    run_vec(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
